uart_rx_param: RTL and testbench

Parametrised UART receiver for the FPGA top level. It is the successor to the fixed 8N1 serial path the test bench drives at 1 Mbaud from a 12 MHz clk. The block adds configurable data width, parity and stop bits, start-bit glitch rejection, per-word error flags and a valid/ready output handshake with overrun detection. It sits between the rx pad and the command decoder.

---
 rtl/uart_rx_param.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with start-bit glitch rejection,
// optional parity, one or two checked stop bits, per-word error flags and a
// valid/ready output holding register with overrun detection.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low (only once the line is armed)
// START     | timing to the middle of the start bit, glitch check there
// DATA      | sampling DATA_BITS data bits mid-bit, LSB first
// PAR       | sampling the parity bit mid-bit
// STOP      | sampling STOP_BITS stop bits mid-bit
// WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 12,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PAR       = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [1:0]           sync_ok;
  logic                 armed;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_r;
  logic                 ferr_r;
  logic                 done;

  // Two-flop synchroniser. The line is only armed once a genuine high has
  // passed through it after reset, so a frame cut by reset is not restarted
  // from its middle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      sync_ok <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      sync_ok <= {sync_ok[0], 1'b1};
      if (sync_ok[1] && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  // Frame FSM: bit timing, sampling, error accumulation and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state  <= START;
            cnt    <= '0;
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
            busy   <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_IDX) begin
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              state    <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PAR: begin
          if (cnt == FULL_M1) begin
            cnt      <= '0;
            stop_idx <= 1'b0;
            // odd mode flags an even total of ones, even mode an odd total
            if (PARITY == 1) begin
              perr_r <= ~(^shreg ^ rx_s);
            end else begin
              perr_r <= ^shreg ^ rx_s;
            end
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == FULL_M1) begin
            cnt    <= '0;
            ferr_r <= ferr_r | ~rx_s;
            if (stop_idx == LAST_STOP) begin
              stop_idx <= 1'b0;
              done     <= 1'b1;
              if (ferr_r || !rx_s) begin
                state <= WAIT_HIGH;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register: loads a completed word unless an unaccepted
  // word is still held, in which case the new word is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_perr  <= perr_r;
          rx_ferr  <= ferr_r;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: a default 8N1 instance (a) and a 7-bit, even
// parity, two stop bit, 9 clk/bit instance (b), with a word scoreboard per
// instance popped on every accepted output word.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       rdy_a = 1'b1, rdy_b = 1'b1;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       perr_a, ferr_a, valid_a, ovr_a, busy_a;
  logic       perr_b, ferr_b, valid_b, ovr_b, busy_b;

  always #5 clk = ~clk;

  uart_rx_param u_a (
    .clk(clk), .rst(rst), .rx(rx_a),
    .rx_data(data_a), .rx_perr(perr_a), .rx_ferr(ferr_a),
    .rx_valid(valid_a), .rx_ready(rdy_a), .overrun(ovr_a), .busy(busy_a)
  );

  uart_rx_param #(.CLKS_PER_BIT(9), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b),
    .rx_data(data_b), .rx_perr(perr_b), .rx_ferr(ferr_b),
    .rx_valid(valid_b), .rx_ready(rdy_b), .overrun(ovr_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       flip;
    logic [1:0] stop_bad;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  word_t       q_a[$];
  word_t       q_b[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          ovr_cnt_a = 0;
  int          valid_cnt_a = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic expect_word(input int inst, input logic [8:0] d, input logic p, input logic f);
    word_t w;
    w.data = d;
    w.perr = p;
    w.ferr = f;
    if (inst == 0) q_a.push_back(w);
    else q_b.push_back(w);
  endtask

  // scoreboard for instance a
  always @(negedge clk) begin
    word_t e;
    if (!rst) begin
      if (ovr_a) ovr_cnt_a++;
      if (valid_a) valid_cnt_a++;
      if (valid_a && rdy_a) begin
        if (q_a.size() == 0) begin
          n_checks++;
          $display("FAIL a_word: got unexpected word data=0x%0h perr=%0b ferr=%0b, required none",
                   data_a, perr_a, ferr_a);
        end else begin
          e = q_a.pop_front();
          check("a_word", {data_a, perr_a, ferr_a}, {e.data[7:0], e.perr, e.ferr});
        end
      end
    end
  end

  // scoreboard for instance b
  always @(negedge clk) begin
    word_t e;
    if (!rst && valid_b && rdy_b) begin
      if (q_b.size() == 0) begin
        n_checks++;
        $display("FAIL b_word: got unexpected word data=0x%0h perr=%0b ferr=%0b, required none",
                 data_b, perr_b, ferr_b);
      end else begin
        e = q_b.pop_front();
        check("b_word", {data_b, perr_b, ferr_b}, {e.data[6:0], e.perr, e.ferr});
      end
    end
  end

  // caller sits 2 time units after a rising edge; so does the return point
  task automatic hold_line(input int inst, input logic v, input int n);
    if (inst == 0) rx_a = v;
    else rx_b = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input int inst, input logic [8:0] d, input logic flip,
                            input logic [1:0] stop_bad);
    int   clks, nb, par, sb;
    logic p;
    if (inst == 0) begin clks = 12; nb = 8; par = 0; sb = 1; end
    else begin clks = 9; nb = 7; par = 2; sb = 2; end
    hold_line(inst, 1'b0, clks);
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      hold_line(inst, d[i], clks);
      p = p ^ d[i];
    end
    if (par != 0) hold_line(inst, ((par == 1) ? ~p : p) ^ flip, clks);
    for (int i = 0; i < sb; i++) hold_line(inst, ~stop_bad[i], clks);
  endtask

  task automatic wait_drain(input int inst, input string name);
    for (int k = 0; k < 60; k++) begin
      if (((inst == 0) ? q_a.size() : q_b.size()) == 0) break;
      @(negedge clk);
    end
    #3;
    check(name, (inst == 0) ? q_a.size() : q_b.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[10];
    int unsigned c0;
    int          o0, v0;

    vecs[0] = '{0, 9'h000, 1'b0, 2'b00, 9'h000, 1'b0, 1'b0};
    vecs[1] = '{0, 9'h0FF, 1'b0, 2'b00, 9'h0FF, 1'b0, 1'b0};
    vecs[2] = '{0, 9'h0C3, 1'b0, 2'b00, 9'h0C3, 1'b0, 1'b0};
    vecs[3] = '{0, 9'h080, 1'b0, 2'b01, 9'h080, 1'b0, 1'b1};
    vecs[4] = '{1, 9'h055, 1'b0, 2'b00, 9'h055, 1'b0, 1'b0};
    vecs[5] = '{1, 9'h055, 1'b1, 2'b00, 9'h055, 1'b1, 1'b0};
    vecs[6] = '{1, 9'h07F, 1'b0, 2'b00, 9'h07F, 1'b0, 1'b0};
    vecs[7] = '{1, 9'h000, 1'b1, 2'b00, 9'h000, 1'b1, 1'b0};
    vecs[8] = '{1, 9'h02A, 1'b0, 2'b10, 9'h02A, 1'b0, 1'b1};
    vecs[9] = '{1, 9'h001, 1'b0, 2'b01, 9'h001, 1'b0, 1'b1};

    // reset state
    repeat (4) @(posedge clk);
    #2;
    check("reset_a", {valid_a, data_a, perr_a, ferr_a, ovr_a, busy_a}, 0);
    check("reset_b", {valid_b, data_b, perr_b, ferr_b, ovr_b, busy_b}, 0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #2;

    // 1: 0x31 on 8N1, latency from start-bit drive to rx_valid
    expect_word(0, 9'h031, 1'b0, 1'b0);
    c0 = cyc;
    fork
      send_frame(0, 9'h031, 1'b0, 2'b00);
      begin
        for (int k = 0; k < 200; k++) begin
          if (valid_a) break;
          @(negedge clk);
        end
        check("t1_latency", cyc - c0, 118);
        @(negedge clk);
        check("t1_single_pulse", valid_a, 0);
      end
    join
    hold_line(0, 1'b1, 24);
    wait_drain(0, "t1_drain");

    // 2: 4-cycle glitch is rejected
    v0 = valid_cnt_a;
    hold_line(0, 1'b0, 4);
    check("t2_busy_rise", busy_a, 1);
    hold_line(0, 1'b1, 16);
    check("t2_busy_fall", busy_a, 0);
    hold_line(0, 1'b1, 24);
    check("t2_no_valid", valid_cnt_a - v0, 0);

    // table of frames for both instances
    for (int i = 0; i < 10; i++) begin
      expect_word(vecs[i].inst, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
      send_frame(vecs[i].inst, vecs[i].data, vecs[i].flip, vecs[i].stop_bad);
      hold_line(vecs[i].inst, 1'b1, 24);
      wait_drain(vecs[i].inst, "vec_drain");
    end

    // 4: overrun with consumer stalled
    rdy_a = 1'b0;
    o0 = ovr_cnt_a;
    expect_word(0, 9'h0A5, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 1'b0, 2'b00);
    send_frame(0, 9'h03C, 1'b0, 2'b00);
    hold_line(0, 1'b1, 24);
    check("t4_overrun_pulses", ovr_cnt_a - o0, 1);
    check("t4_held_word", {valid_a, data_a}, {1'b1, 8'hA5});
    rdy_a = 1'b1;
    @(posedge clk);
    #2;
    check("t4_valid_fall", valid_a, 0);
    wait_drain(0, "t4_drain");

    // 5: break gives exactly one framing-error word, then a clean frame
    expect_word(0, 9'h000, 1'b0, 1'b1);
    hold_line(0, 1'b0, 240);
    check("t5_wait_high_busy", busy_a, 1);
    wait_drain(0, "t5_break_word");
    hold_line(0, 1'b1, 6);
    check("t5_back_idle", busy_a, 0);
    hold_line(0, 1'b1, 18);
    expect_word(0, 9'h07E, 1'b0, 1'b0);
    send_frame(0, 9'h07E, 1'b0, 2'b00);
    hold_line(0, 1'b1, 24);
    wait_drain(0, "t5_after_break");

    // 6: reset during bit 3 of 0xF0 while a word is held
    rdy_a = 1'b0;
    send_frame(0, 9'h05A, 1'b0, 2'b00);
    hold_line(0, 1'b1, 24);
    check("t6_held_before_rst", {valid_a, data_a}, {1'b1, 8'h5A});
    hold_line(0, 1'b0, 12);
    hold_line(0, 1'b0, 36);
    hold_line(0, 1'b0, 5);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("t6_reset_outputs", {valid_a, data_a, perr_a, ferr_a, ovr_a, busy_a}, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    rdy_a = 1'b1;
    hold_line(0, 1'b0, 5);
    hold_line(0, 1'b1, 48);
    hold_line(0, 1'b1, 12);
    hold_line(0, 1'b1, 24);
    check("t6_no_spurious", {valid_a, busy_a}, 0);
    expect_word(0, 9'h012, 1'b0, 1'b0);
    send_frame(0, 9'h012, 1'b0, 2'b00);
    hold_line(0, 1'b1, 24);
    wait_drain(0, "t6_after_reset");
    wait_drain(1, "b_final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
